// File: rtl/bit_population_counter_pipe.sv
// ============================================================================
// Module      : bit_population_counter_pipe
// Description : Pipelined masked ones/zeros population counter with a
//               registered adder tree and full-pipeline backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_population_counter_pipe #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic [WIDTH-1:0]       mask_i,
    input  logic                   mode_i,
    input  logic                   data_val_i,
    output logic                   data_ready_o,
    output logic [$clog2(WIDTH):0] data_o,
    output logic                   data_val_o,
    input  logic                   data_ready_i
);

    localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int T  = $clog2(N);
    localparam int CW = $clog2(CHUNK) + 1;
    localparam int SW = CW + T;
    localparam int OW = $clog2(WIDTH) + 1;

    // Every tree level shares one storage width; entries past a level's node
    // count stay zero.
    logic [SW-1:0]    lvl_q [0:T][0:N-1];
    logic [SW-1:0]    lvl_d [0:T][0:N-1];
    logic [T:0]       vld_q;
    logic [T:0]       vld_d;
    logic [WIDTH-1:0] eff;
    logic             stall;

    function automatic int nodes(input int lvl);
        return (N + (1 << lvl) - 1) >> lvl;
    endfunction

    assign eff          = mask_i & (data_i ^ {WIDTH{mode_i}});
    assign stall        = vld_q[T] & ~data_ready_i;
    assign data_ready_o = ~stall;
    assign data_val_o   = vld_q[T];
    assign data_o       = OW'(lvl_q[T][0]);

    always_comb begin
        logic [SW-1:0] acc;
        int            idx;
        int            a_idx;
        int            b_idx;
        for (int l = 0; l <= T; l++) begin
            for (int i = 0; i < N; i++) begin
                lvl_d[l][i] = '0;
            end
        end
        acc = '0;
        // Indices beyond WIDTH belong to the short last chunk and never count.
        for (int k = 0; k < N; k++) begin
            acc = '0;
            for (int b = 0; b < CHUNK; b++) begin
                idx = k * CHUNK + b;
                if (idx < WIDTH) begin
                    acc = acc + SW'(eff[(idx < WIDTH) ? idx : 0]);
                end
            end
            lvl_d[0][k] = acc;
        end
        for (int l = 0; l < T; l++) begin
            for (int i = 0; i < N; i++) begin
                a_idx = (2 * i < N) ? 2 * i : 0;
                b_idx = (2 * i + 1 < N) ? 2 * i + 1 : 0;
                if (i < nodes(l + 1)) begin
                    if (2 * i + 1 < nodes(l)) begin
                        lvl_d[l + 1][i] = lvl_q[l][a_idx] + lvl_q[l][b_idx];
                    end else begin
                        lvl_d[l + 1][i] = lvl_q[l][a_idx];
                    end
                end
            end
        end
        vld_d[0] = data_val_i;
        for (int l = 1; l <= T; l++) begin
            vld_d[l] = vld_q[l - 1];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int l = 0; l <= T; l++) begin
                for (int i = 0; i < N; i++) begin
                    lvl_q[l][i] <= '0;
                end
            end
            vld_q <= '0;
        end else if (!stall) begin
            lvl_q <= lvl_d;
            vld_q <= vld_d;
        end
    end

endmodule

`default_nettype wire
